// File: rtl/survivor_stack.sv
// LIFO survivor-path memory between the ACS pass and traceback.
// Back-pointer arrays are pushed once per step, then replayed newest-first for traceback.
module survivor_stack #(
    parameter int STATE_REG_NUM = 8,
    parameter int STATE_NUM     = 256,
    parameter int DEPTH         = 64,
    parameter int CW            = $clog2(DEPTH+1)
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               en_w,
    input  logic                               i_last,
    input  logic [STATE_NUM*STATE_REG_NUM-1:0] i_prv_st,
    output logic                               o_ready,
    output logic                               o_en_t,
    output logic [STATE_NUM*STATE_REG_NUM-1:0] o_bck_prv_st,
    output logic                               o_td_empty,
    output logic                               o_ood,
    output logic                               o_overflow
);
    localparam int W  = STATE_NUM*STATE_REG_NUM;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {FILL, TRACE} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            en_t_q, ovf_q;
    logic            wr_acc;
    logic [AW-1:0]   wr_idx, rd_idx;
    logic [W-1:0]    mem [DEPTH];

    assign wr_acc = en_w && (state == FILL);
    assign wr_idx = AW'(cnt);
    // cnt >= 1 whenever TRACE reads, so the decrement cannot wrap where it matters
    assign rd_idx = AW'(cnt - CW'(1));

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            FILL: begin
                if (en_w) begin
                    cnt_nxt = cnt + CW'(1);
                    if (i_last || (cnt_nxt == CW'(DEPTH)))
                        state_nxt = TRACE;
                end
            end
            TRACE: begin
                cnt_nxt = cnt - CW'(1);
                if (cnt == CW'(1))
                    state_nxt = FILL;
            end
            default: begin
                state_nxt = FILL;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= FILL;
            cnt    <= '0;
            en_t_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            en_t_q <= (state_nxt == TRACE);
            if (en_w && (state == TRACE))
                ovf_q <= 1'b1;
        end
    end

    // Storage is deliberately left unreset; only occupancy tracks validity
    always_ff @(posedge clk) begin
        if (wr_acc)
            mem[wr_idx] <= i_prv_st;
    end

    assign o_ready      = (state == FILL);
    assign o_en_t       = en_t_q;
    assign o_bck_prv_st = (state == TRACE) ? mem[rd_idx] : '0;
    assign o_td_empty   = (cnt == '0);
    assign o_ood        = (state == TRACE) && (cnt == CW'(1));
    assign o_overflow   = ovf_q;

endmodule

// File: tb/tb_survivor_stack.sv
// Bench for survivor_stack: queue-based stack model checked every cycle, plus directed literal checks.
module tb_survivor_stack;
    localparam int SRN   = 8;
    localparam int SN    = 256;
    localparam int DEPTH = 64;
    localparam int W     = SRN*SN;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         en_w = 1'b0;
    logic         i_last = 1'b0;
    logic [W-1:0] i_prv_st = '0;
    logic         o_ready, o_en_t, o_td_empty, o_ood, o_overflow;
    logic [W-1:0] o_bck_prv_st;

    always #5 clk = ~clk;

    survivor_stack #(.STATE_REG_NUM(SRN), .STATE_NUM(SN), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .en_w(en_w), .i_last(i_last), .i_prv_st(i_prv_st),
        .o_ready(o_ready), .o_en_t(o_en_t), .o_bck_prv_st(o_bck_prv_st),
        .o_td_empty(o_td_empty), .o_ood(o_ood), .o_overflow(o_overflow)
    );

    int n_vec = 0;
    int n_err = 0;
    bit started = 1'b0;

    task automatic chk(string nm, logic got, logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic chka(string nm, logic [W-1:0] got, logic [W-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got low64 %h expected low64 %h at %0t", nm, got[63:0], exp[63:0], $time);
        end
    endtask

    function automatic logic [W-1:0] mk_a(int k);
        logic [W-1:0] r;
        r = '0;
        for (int s = 0; s < SN; s++) r[s*SRN +: SRN] = SRN'(s + k);
        return r;
    endfunction

    function automatic logic [W-1:0] rnd_arr();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < W/32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    // Reference: a stack of whole arrays and a mode flag
    logic [W-1:0] stk[$];
    bit           tracing = 1'b0;
    bit           m_ovf = 1'b0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            stk.delete();
            tracing <= 1'b0;
            m_ovf   <= 1'b0;
        end else if (!tracing) begin
            if (en_w) begin
                stk.push_back(i_prv_st);
                tracing <= i_last || (stk.size() == DEPTH);
            end
        end else begin
            if (en_w) m_ovf <= 1'b1;
            void'(stk.pop_back());
            tracing <= (stk.size() != 0);
        end
    end

    logic [W-1:0] exp_bck;
    always @(negedge clk) begin
        if (started) begin
            exp_bck = '0;
            if (tracing && stk.size() > 0) exp_bck = stk[$];
            chk("ready", o_ready, !tracing);
            chk("en_t", o_en_t, tracing);
            chk("ood", o_ood, tracing && stk.size() == 1);
            chk("empty", o_td_empty, stk.size() == 0);
            chk("overflow", o_overflow, m_ovf);
            chka("bck", o_bck_prv_st, exp_bck);
        end
    end

    task automatic tick(bit e, bit l, logic [W-1:0] d);
        en_w = e; i_last = l; i_prv_st = d;
        @(posedge clk);
        @(negedge clk);
        en_w = 1'b0; i_last = 1'b0;
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, '0);
    endtask

    logic [W-1:0] fd [DEPTH];

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_en_t", o_en_t, 1'b0);
        chk("rst_ood", o_ood, 1'b0);
        chk("rst_ovf", o_overflow, 1'b0);
        chk("rst_empty", o_td_empty, 1'b1);
        chk("rst_ready", o_ready, 1'b1);
        chka("rst_bck", o_bck_prv_st, '0);
        rst = 1'b1;
        started = 1'b1;

        // basic 4-entry frame
        for (int k = 0; k < 4; k++) tick(1'b1, k == 3, mk_a(k));
        chk("f4_en_t", o_en_t, 1'b1);
        chka("f4_a3", o_bck_prv_st, mk_a(3));
        chk("f4_ood0", o_ood, 1'b0);
        idle(); chka("f4_a2", o_bck_prv_st, mk_a(2));
        idle(); chka("f4_a1", o_bck_prv_st, mk_a(1));
        idle(); chka("f4_a0", o_bck_prv_st, mk_a(0)); chk("f4_ood", o_ood, 1'b1);
        idle(); chk("f4_done_en", o_en_t, 1'b0); chk("f4_done_empty", o_td_empty, 1'b1);

        // i_last without en_w is ignored
        tick(1'b1, 1'b0, mk_a(10));
        tick(1'b1, 1'b0, mk_a(11));
        tick(1'b0, 1'b1, '0);
        chk("lastonly_en_t", o_en_t, 1'b0);
        chk("lastonly_empty", o_td_empty, 1'b0);
        tick(1'b1, 1'b1, mk_a(12)); chka("lo_12", o_bck_prv_st, mk_a(12));
        idle(); chka("lo_11", o_bck_prv_st, mk_a(11)); chk("lo_ood11", o_ood, 1'b0);
        idle(); chka("lo_10", o_bck_prv_st, mk_a(10)); chk("lo_ood10", o_ood, 1'b1);
        idle();

        // write dropped during trace
        chk("ovf_pre", o_overflow, 1'b0);
        for (int k = 0; k < 4; k++) tick(1'b1, k == 3, mk_a(k));
        idle(); chk("ovf_ready", o_ready, 1'b0);
        tick(1'b1, 1'b0, mk_a(99));
        chk("ovf_set", o_overflow, 1'b1);
        chka("ovf_a1", o_bck_prv_st, mk_a(1));
        idle(); chka("ovf_a0", o_bck_prv_st, mk_a(0));
        idle(); chk("ovf_sticky", o_overflow, 1'b1); chk("ovf_empty", o_td_empty, 1'b1);

        // async reset in 2nd trace cycle
        for (int k = 0; k < 4; k++) tick(1'b1, k == 3, mk_a(k));
        idle();
        #1 rst = 1'b0;
        #1;
        chk("mr_en_t", o_en_t, 1'b0);
        chk("mr_ood", o_ood, 1'b0);
        chk("mr_empty", o_td_empty, 1'b1);
        chk("mr_ovf", o_overflow, 1'b0);
        chka("mr_bck", o_bck_prv_st, '0);
        @(negedge clk);
        rst = 1'b1;
        tick(1'b1, 1'b0, mk_a(20));
        tick(1'b1, 1'b1, mk_a(21)); chka("mr_21", o_bck_prv_st, mk_a(21));
        idle(); chka("mr_20", o_bck_prv_st, mk_a(20)); chk("mr_ood20", o_ood, 1'b1);
        idle();

        // single-entry frame, then back-to-back write
        tick(1'b1, 1'b1, mk_a(30));
        chka("se_bck", o_bck_prv_st, mk_a(30)); chk("se_ood", o_ood, 1'b1); chk("se_en", o_en_t, 1'b1);
        idle(); chk("se_after_en", o_en_t, 1'b0);
        tick(1'b1, 1'b0, mk_a(31));
        chk("se_next_empty", o_td_empty, 1'b0); chk("se_next_ready", o_ready, 1'b1);
        tick(1'b1, 1'b1, mk_a(32)); chka("se_32", o_bck_prv_st, mk_a(32));
        idle(); chka("se_31", o_bck_prv_st, mk_a(31)); chk("se_ood31", o_ood, 1'b1);
        idle();

        // forced trace when full
        for (int i = 0; i < DEPTH; i++) begin
            fd[i] = rnd_arr();
            tick(1'b1, 1'b0, fd[i]);
        end
        for (int j = 1; j <= DEPTH; j++) begin
            chk("forced_en", o_en_t, 1'b1);
            chka("forced_bck", o_bck_prv_st, fd[DEPTH-j]);
            chk("forced_ood", o_ood, j == DEPTH);
            idle();
        end
        chk("forced_done", o_en_t, 1'b0);

        // random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            tick($urandom_range(0, 9) < 6, $urandom_range(0, 15) == 0, rnd_arr());
        end

        started = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
